// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             div_load;
  logic [WIDTH-1:0] div_val;
  logic             clk_out;
  logic             period_tick;
  logic             running;
  logic [WIDTH-1:0] div_active;
  logic             load_busy;
  logic             load_err;

  modport master (
    output en, div_load, div_val,
    input  clk_out, period_tick, running, div_active, load_busy, load_err
  );

  modport slave (
    input  en, div_load, div_val,
    output clk_out, period_tick, running, div_active, load_busy, load_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// Run-time programmable 50% duty integer clock divider (N >= 2, odd or even).
// Divisor reloads are deferred to an output-period boundary so clk_out never glitches.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         rst,
  clk_div_prog_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             p_q, p_d;
  logic             n_q;
  logic             odd_q;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] half, last, cnt_inc;
  logic             at_end, ld_ok, apply;

  // ceil(N/2) without needing a WIDTH+1 bit intermediate
  assign half    = (div_q >> 1) + {{(WIDTH-1){1'b0}}, div_q[0]};
  assign last    = div_q - WIDTH'(1);
  assign cnt_inc = cnt_q + WIDTH'(1);
  assign at_end  = (cnt_q == last);
  assign ld_ok   = bus.div_load && (bus.div_val >= WIDTH'(2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    tick_d  = 1'b0;
    apply   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        p_d   = 1'b0;
        if (bus.en) begin
          state_d = RUN;
          p_d     = 1'b1;
          tick_d  = 1'b1;
          apply   = pend_v_q;
        end
      end
      RUN: begin
        if (at_end) begin
          cnt_d = '0;
          if (bus.en) begin
            p_d    = 1'b1;
            tick_d = 1'b1;
            apply  = pend_v_q;
          end else begin
            p_d     = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
          p_d   = (cnt_inc < half);
        end
      end
      default: state_d = IDLE;
    endcase
    div_d = apply ? pend_q : div_q;
    // A load landing on the applying edge stays pending for the next boundary
    pend_d   = ld_ok ? bus.div_val : pend_q;
    pend_v_d = ld_ok ? 1'b1 : (apply ? 1'b0 : pend_v_q);
    err_d    = bus.div_load && !ld_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= DEF;
      pend_q   <= DEF;
      pend_v_q <= 1'b0;
      p_q      <= 1'b0;
      odd_q    <= DEF[0];
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      p_q      <= p_d;
      // Follows the new divisor on the same edge p_q rises, while n_q is still low
      odd_q    <= div_d[0];
      tick_q   <= tick_d;
      err_q    <= err_d;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) n_q <= 1'b0;
    else     n_q <= p_q;
  end

  assign bus.clk_out     = p_q & (n_q | ~odd_q);
  assign bus.period_tick = tick_q;
  assign bus.running     = (state_q == RUN);
  assign bus.div_active  = div_q;
  assign bus.load_busy   = pend_v_q;
  assign bus.load_err    = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: waveform captures at half-cycle resolution vs hand-derived patterns.
module tb_clk_div_prog;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  clk_div_prog_if #(.WIDTH(WIDTH)) bus_if ();

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples every half cycle starting now; first sample ends up in the MSB of the nh bits
  task automatic capture(input int nh, output logic [63:0] co, output logic [63:0] tk);
    co = '0;
    tk = '0;
    for (int i = 0; i < nh; i++) begin
      co = {co[62:0], bus_if.clk_out};
      tk = {tk[62:0], bus_if.period_tick};
      #5;
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    bus_if.div_load = 1'b1;
    bus_if.div_val  = v;
    step();
    bus_if.div_load = 1'b0;
  endtask

  logic [63:0] co, tk;
  logic        w [0:511];
  int          ones, ticks;

  initial begin
    bus_if.en       = 1'b0;
    bus_if.div_load = 1'b0;
    bus_if.div_val  = '0;

    // Reset values
    #12;
    chk("rst_clk_out", bus_if.clk_out, 0);
    chk("rst_tick", bus_if.period_tick, 0);
    chk("rst_running", bus_if.running, 0);
    chk("rst_div_active", bus_if.div_active, 3);
    chk("rst_busy", bus_if.load_busy, 0);
    chk("rst_err", bus_if.load_err, 0);
    rst = 1'b0;
    step();

    // Default N=3: start at posedge 25
    bus_if.en = 1'b1;
    step();
    chk("n3_running", bus_if.running, 1);
    chk("n3_div_active", bus_if.div_active, 3);
    capture(12, co, tk);
    chk("n3_wave", co, 64'(12'b011100_011100));
    chk("n3_tick", tk, 64'(12'b110000_110000));

    // Stop at cnt=0 of a N=3 period: finishes two more cycles then idles
    bus_if.en = 1'b0;
    step();
    step();
    chk("stop3_running_still", bus_if.running, 1);
    step();
    chk("stop3_running", bus_if.running, 0);
    chk("stop3_clk_out", bus_if.clk_out, 0);

    // Even divisor loaded while idle
    load(8'd4);
    chk("n4_busy", bus_if.load_busy, 1);
    chk("n4_not_yet", bus_if.div_active, 3);
    bus_if.en = 1'b1;
    step();
    chk("n4_div_active", bus_if.div_active, 4);
    chk("n4_busy_clr", bus_if.load_busy, 0);
    capture(16, co, tk);
    chk("n4_wave", co, 64'(16'b11110000_11110000));
    chk("n4_tick", tk, 64'(16'b11000000_11000000));

    // Now at cnt=0 of N=4; load 5 sampled at cnt 0->1, applied at next boundary
    load(8'd5);
    step();
    step();
    chk("n5_pending", bus_if.div_active, 4);
    step();
    chk("n5_div_active", bus_if.div_active, 5);
    chk("n5_tick", bus_if.period_tick, 1);
    // Load 8 sampled on the edge where cnt becomes 2
    step();
    load(8'd8);
    chk("busy_c2", bus_if.load_busy, 1);
    step();
    chk("busy_c3", bus_if.load_busy, 1);
    step();
    chk("busy_c4", bus_if.load_busy, 1);
    chk("n5_tick_c4", bus_if.period_tick, 0);
    chk("n5_still_c4", bus_if.div_active, 5);
    step();
    chk("busy_clr", bus_if.load_busy, 0);
    chk("n8_div_active", bus_if.div_active, 8);
    chk("n8_tick", bus_if.period_tick, 1);
    capture(16, co, tk);
    chk("n8_wave", co, 64'(16'hFF00));
    chk("n8_tickw", tk, 64'(16'hC000));

    // Back-to-back loads 6 then 7 at cnt=0 of N=8; 7 wins at the boundary 8 cycles on
    bus_if.div_load = 1'b1;
    bus_if.div_val  = 8'd6;
    step();
    bus_if.div_val  = 8'd7;
    step();
    bus_if.div_load = 1'b0;
    chk("b2b_busy", bus_if.load_busy, 1);
    for (int i = 0; i < 5; i++) step();
    chk("b2b_not_yet", bus_if.div_active, 8);
    step();
    chk("b2b_div_active", bus_if.div_active, 7);
    chk("b2b_busy_clr", bus_if.load_busy, 0);

    // Invalid loads at N=7 (cnt=0 now)
    load(8'd1);
    chk("err1_pulse", bus_if.load_err, 1);
    chk("err1_busy", bus_if.load_busy, 0);
    step();
    chk("err1_clear", bus_if.load_err, 0);
    load(8'd0);
    chk("err0_pulse", bus_if.load_err, 1);
    step();
    chk("err0_clear", bus_if.load_err, 0);
    chk("err_div_active", bus_if.div_active, 7);
    step();
    step();
    step();
    capture(14, co, tk);
    chk("n7_wave", co, 64'(14'b01111111000000));
    chk("n7_tick", tk, 64'(14'b11000000000000));

    // Stop: drop en at cnt=1 of N=7
    step();
    bus_if.en = 1'b0;
    capture(10, co, tk);
    chk("stop7_wave", co, 64'(10'b1111110000));
    chk("stop7_running_c6", bus_if.running, 1);
    #10;
    chk("stop7_running", bus_if.running, 0);
    chk("stop7_clk_out", bus_if.clk_out, 0);
    step();
    step();
    chk("idle_clk_out", bus_if.clk_out, 0);
    bus_if.en = 1'b1;
    step();
    chk("restart_running", bus_if.running, 1);
    capture(14, co, tk);
    chk("restart_wave", co, 64'(14'b01111111000000));
    chk("restart_tick", tk, 64'(14'b11000000000000));

    // Async reset in the high phase (right after a negedge), no clock edge involved
    #5;
    chk("pre_rst_high", bus_if.clk_out, 1);
    bus_if.div_load = 1'b1;
    bus_if.div_val  = 8'd9;
    #1;
    rst = 1'b1;
    bus_if.en = 1'b0;
    bus_if.div_load = 1'b0;
    #1;
    chk("arst_clk_out", bus_if.clk_out, 0);
    chk("arst_tick", bus_if.period_tick, 0);
    chk("arst_running", bus_if.running, 0);
    chk("arst_div_active", bus_if.div_active, 3);
    chk("arst_busy", bus_if.load_busy, 0);
    rst = 1'b0;
    step();

    // Max divisor 255
    load(8'd255);
    chk("n255_busy", bus_if.load_busy, 1);
    bus_if.en = 1'b1;
    step();
    chk("n255_div_active", bus_if.div_active, 255);
    ones  = 0;
    ticks = 0;
    for (int i = 0; i < 510; i++) begin
      w[i]  = bus_if.clk_out;
      ones  = ones + int'(bus_if.clk_out);
      ticks = ticks + int'(bus_if.period_tick);
      #5;
    end
    chk("n255_high_halves", ones, 255);
    chk("n255_ticks", ticks, 2);
    chk("n255_first", w[0], 0);
    chk("n255_rise", w[1], 1);
    chk("n255_last_high", w[255], 1);
    chk("n255_fall", w[256], 0);
    chk("n255_end_low", w[509], 0);
    chk("n255_wrap_tick", bus_if.period_tick, 1);
    chk("n255_wrap_clk", bus_if.clk_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Run-time programmable integer clock divider. It produces a 50 % duty-cycle `clk_out` for any divisor N ≥ 2, odd or even, from a single source clock. The divisor can be reloaded on the fly and takes effect only at an output-period boundary, so `clk_out` never glitches or produces a short pulse. It sits at the clock-generation front end and feeds derived clocks and period strobes to downstream logic.

## Interface
- `WIDTH`, 8, width of the divisor and counter; N range is 2 .. 2^WIDTH−1.
- `DEFAULT_DIV`, 3, active divisor after reset; must satisfy 2 ≤ DEFAULT_DIV ≤ 2^WIDTH−1.
- `clk`  in  1  source clock; both edges are used.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  run request, sampled on posedge `clk`.
- `div_load`  in  1  one-cycle strobe; requests `div_val` as the new divisor.
- `div_val`  in  WIDTH  requested divisor N.
- `clk_out`  out  1  divided clock, 50 % duty.
- `period_tick`  out  1  registered one-`clk` pulse, high in the first `clk` cycle of each output period.
- `running`  out  1  high while in RUN.
- `div_active`  out  WIDTH  divisor currently in use.
- `load_busy`  out  1  a pending divisor is waiting for a period boundary.
- `load_err`  out  1  one-cycle pulse: the last `div_load` was rejected (`div_val` < 2).

## Operation
- **Registers:** `cnt[WIDTH-1:0]`, `div_active`, `div_pend`, `pend_v`, `p_q` (posedge), `n_q` (negedge copy of `p_q`), `state` ∈ {IDLE, RUN}.
- **H:** H = ceil(N/2) with N = `div_active`.
- **`p_q` in RUN:** `p_q` is high for `cnt` ∈ [0, H−1] and low otherwise. It is registered from next-state `cnt`, so it rises on the same posedge where `cnt` loads 0.
- **Negedge stage:** `n_q` <= `p_q` on every negedge `clk`.
- **Even N:** `clk_out` = `p_q`. High for N/2 cycles, low for N/2 cycles.
- **Odd N:** `clk_out` = `p_q` & `n_q`. High for H − ½ = N/2 cycles and low for N/2 cycles. The rising edge of `clk_out` lags the period start by ½ `clk`.
- **Output mux:** the even/odd selection is a registered function of `div_active`. It changes only at a period boundary, while `p_q` is low.
- **IDLE:**
  - `cnt` = 0, `p_q` = 0.
  - On a posedge with `en` = 1: apply the pending divisor (if any), set `cnt` <= 0 and `p_q` <= 1, and go to RUN.
- **RUN:**
  - `cnt` increments each posedge.
  - At `cnt` = N−1 with `en` = 0: go to IDLE, `p_q` <= 0.
  - At `cnt` = N−1 with `en` = 1: set `cnt` <= 0, apply the pending divisor, `p_q` <= 1.
- **`en` deassertion:** never truncates a period. Deasserting `en` mid-period finishes the current period first.
- **Load, valid value:** `div_load` with `div_val` ≥ 2 sets `div_pend` <= `div_val` and `pend_v` <= 1.
  - A second load while pending overwrites `div_pend`; last write wins.
  - A load that coincides with a boundary posedge is applied at the following boundary.
- **Load, invalid value:** `div_load` with `div_val` < 2 pulses `load_err` for 1 cycle. `div_pend` and `pend_v` are unchanged.
- **Applying a pending divisor:** `div_active` <= `div_pend`, `pend_v` <= 0.
- **`load_busy`:** equals `pend_v`.
- **Counter range:** `cnt` never exceeds N−1, and all compares are WIDTH bits wide, so there is no overflow at N = 2^WIDTH−1.

## Timing
- **Reset values:** `cnt` = 0, `state` = IDLE, `p_q` = `n_q` = 0, `clk_out` = 0, `period_tick` = 0, `running` = 0, `div_active` = DEFAULT_DIV, `pend_v` = 0, `load_busy` = 0, `load_err` = 0.
- **Reset mid-operation:** `clk_out` drops immediately (async) and every register returns to its reset value.
- **Start latency:** `en` is high at posedge k. `clk_out` rises at posedge k for even N, or at negedge k+½ for odd N.
- **`period_tick`:** high during the cycle following each posedge where `cnt` loads 0 in RUN.
- **`running`:** registered; high from the start posedge until the boundary posedge that enters IDLE.
- **`load_err`:** asserted the cycle after the strobe.
- **`load_busy`:** asserted the cycle after the strobe; cleared on the applying boundary posedge.

## Test plan
- **Reset default:** reset, then `en` = 1 with DEFAULT_DIV = 3 -> `clk_out` period 3 `clk`, high 1.5 `clk`, rising on negedges; `period_tick` every 3 cycles.
- **Even divisor:** load 4 while idle, then `en` = 1 -> `clk_out` 2 high / 2 low; `div_active` = 4.
- **Mid-period reload:** running at N = 5, load 8 at `cnt` = 2 -> current 5-cycle period completes, next period is 8; `load_busy` high for exactly 3 cycles. Back-to-back loads 6 then 7 -> 7 applied.
- **Invalid load:** load 1 (and 0) -> `load_err` 1-cycle pulse each; `div_active` and `clk_out` unaffected.
- **Stop:** deassert `en` at `cnt` = 1 with N = 7 -> period finishes, `clk_out` low, `running` = 0 after the boundary. Reassert -> restarts at `cnt` = 0 with no short pulse.
- **Async reset and max divisor:** assert `rst` mid-high-phase -> all outputs reach reset values immediately. Then N = 255 -> 127.5 / 127.5 duty, `cnt` wraps 254 -> 0.
